// File: rtl/muldiv_pkg.sv
// Shared types and step-count helpers for the execute-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } muldiv_state_t;

  function automatic int mul_steps(input int xlen, input int mul_bits);
    return xlen / mul_bits;
  endfunction

  function automatic int div_steps(input int xlen, input int div_bits);
    return xlen / div_bits;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step retiring DIV_BITS quotient bits, MSB first.
module muldiv_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0]     rem_in,
  input  logic [DIV_BITS-1:0] dvd_bits,
  input  logic [XLEN-1:0]     divisor,
  output logic [XLEN-1:0]     rem_out,
  output logic [DIV_BITS-1:0] quo_bits
);

  logic [XLEN-1:0] r;
  logic [XLEN:0]   t;
  logic [XLEN:0]   diff;

  // With divisor != 0 the partial remainder stays below the divisor, so the
  // top bit of the trial difference is a clean borrow flag.
  always_comb begin
    r        = rem_in;
    t        = '0;
    diff     = '0;
    quo_bits = '0;
    for (int i = DIV_BITS - 1; i >= 0; i--) begin
      t    = {r, dvd_bits[i]};
      diff = t - {1'b0, divisor};
      if (!diff[XLEN]) begin
        r           = diff[XLEN-1:0];
        quo_bits[i] = 1'b1;
      end else begin
        r = t[XLEN-1:0];
      end
    end
    rem_out = r;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shared shift-add / restoring datapath,
// div-by-zero and overflow fast path, last-result cache and flush (kill) support.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int MUL_STEPS = mul_steps(XLEN, MUL_BITS);
  localparam int DIV_STEPS = div_steps(XLEN, DIV_BITS);
  localparam int MAX_STEPS = (MUL_STEPS > DIV_STEPS) ? MUL_STEPS : DIV_STEPS;
  localparam int CNT_W     = $clog2(MAX_STEPS) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic n, input logic [2*XLEN-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_e;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [2:0]      op_q;
  logic [1:0]      mode_q;
  logic            a_neg_q, b_neg_q;

  logic            cache_vld_q, cache_div_q;
  logic [1:0]      cache_mode_q;
  logic [XLEN-1:0] cache_a_q, cache_b_q, cache_hi_q, cache_lo_q;
  logic [XLEN-1:0] result_q;

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic            a_sgn, b_sgn, rs1_neg, rs2_neg, rs2_zero, ovf;
  logic            fast, hit;
  logic [1:0]      mode_in;
  logic [XLEN-1:0] mag1, mag2, fast_val, hit_val, quick_val;
  logic            ld, quick, fix_wr, step;

  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [MUL_BITS-1:0]      mul_digit;
  logic [XLEN-1:0]          div_rem;
  logic [DIV_BITS-1:0]      div_q;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_hi, fix_lo, fix_res;

  // Issue-cycle decode: signedness, magnitudes, fast path and cache lookup
  assign op_e     = muldiv_op_t'(op);
  assign rs1_s    = rs1;
  assign rs2_s    = rs2;
  assign a_sgn    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign b_sgn    = op[2] ? ~op[0] : ~op[1];
  assign mode_in  = {a_sgn, b_sgn};
  assign rs1_neg  = a_sgn & (rs1_s < 0);
  assign rs2_neg  = b_sgn & (rs2_s < 0);
  assign mag1     = cneg(rs1_neg, rs1);
  assign mag2     = cneg(rs2_neg, rs2);
  assign rs2_zero = (rs2 == '0);
  assign ovf      = a_sgn & (rs1 == XMIN) & (rs2 == '1);
  assign fast     = op[2] & (rs2_zero | ovf);
  assign fast_val = rs2_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : XMIN);

  assign hit = cache_vld_q && (cache_a_q == rs1) && (cache_b_q == rs2) &&
               (cache_div_q == op[2]) &&
               ((op_e == OP_MUL) || (cache_mode_q == mode_in));
  assign hit_val   = op[2] ? (op[1] ? cache_hi_q : cache_lo_q)
                           : ((op_e == OP_MUL) ? cache_lo_q : cache_hi_q);
  assign quick_val = fast ? fast_val : hit_val;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    ld      = 1'b0;
    quick   = 1'b0;
    fix_wr  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          if (fast || hit) begin
            quick   = 1'b1;
            state_d = S_DONE;
          end else begin
            busy    = 1'b1;
            ld      = 1'b1;
            state_d = op[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          busy = 1'b1;
          step = 1'b1;
          if (cnt_q == ((state_q == S_MUL) ? MUL_LAST : DIV_LAST)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          busy    = 1'b1;
          fix_wr  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = ~kill;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) busy = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cache_vld_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ld)        cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + CNT_W'(1);
      if (fix_wr)    cache_vld_q <= 1'b1;
      if (quick)       result_q <= quick_val;
      else if (fix_wr) result_q <= fix_res;
    end
  end

  // Iteration datapath: acc_hi/acc_lo hold {product} or {remainder, dividend->quotient}
  assign mul_digit = acc_lo_q[MUL_BITS-1:0];
  assign mul_sum   = {{MUL_BITS{1'b0}}, acc_hi_q} +
                     {{MUL_BITS{1'b0}}, opnd_q} * {{XLEN{1'b0}}, mul_digit};

  muldiv_div_step #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div_step (
    .rem_in   (acc_hi_q),
    .dvd_bits (acc_lo_q[XLEN-1 -: DIV_BITS]),
    .divisor  (opnd_q),
    .rem_out  (div_rem),
    .quo_bits (div_q)
  );

  // Sign correction and result selection
  assign prod    = cneg2(a_neg_q ^ b_neg_q, {acc_hi_q, acc_lo_q});
  assign quo     = cneg(a_neg_q ^ b_neg_q, acc_lo_q);
  assign rmd     = cneg(a_neg_q, acc_hi_q);
  assign fix_hi  = op_q[2] ? rmd : prod[2*XLEN-1:XLEN];
  assign fix_lo  = op_q[2] ? quo : prod[XLEN-1:0];
  assign fix_res = op_q[2] ? (op_q[1] ? rmd : quo)
                           : ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk) begin
    if (ld) begin
      rs1_q    <= rs1;
      rs2_q    <= rs2;
      op_q     <= op;
      mode_q   <= mode_in;
      a_neg_q  <= rs1_neg;
      b_neg_q  <= rs2_neg;
      acc_hi_q <= '0;
      acc_lo_q <= op[2] ? mag1 : mag2;
      opnd_q   <= op[2] ? mag2 : mag1;
    end else if (step && state_q == S_MUL) begin
      acc_hi_q <= mul_sum[XLEN+MUL_BITS-1:MUL_BITS];
      acc_lo_q <= {mul_sum[MUL_BITS-1:0], acc_lo_q[XLEN-1:MUL_BITS]};
    end else if (step && state_q == S_DIV) begin
      acc_hi_q <= div_rem;
      acc_lo_q <= {acc_lo_q[XLEN-DIV_BITS-1:0], div_q};
    end
    if (fix_wr) begin
      cache_a_q    <= rs1_q;
      cache_b_q    <= rs2_q;
      cache_div_q  <= op_q[2];
      cache_mode_q <= mode_q;
      cache_hi_q   <= fix_hi;
      cache_lo_q   <= fix_lo;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: default radix instance plus a MUL_BITS=1/DIV_BITS=2 instance.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, kill = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
  logic        sel = 1'b0;
  logic        busy_w, done_w;
  logic [31:0] res_w;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(1)) u_dut0 (
    .clk (clk), .rst (rst), .start (start0), .op (op), .rs1 (rs1), .rs2 (rs2),
    .kill (kill), .busy (busy0), .done (done0), .result (res0)
  );

  ex_muldiv_unit #(.XLEN(32), .MUL_BITS(1), .DIV_BITS(2)) u_dut1 (
    .clk (clk), .rst (rst), .start (start1), .op (op), .rs1 (rs1), .rs2 (rs2),
    .kill (kill), .busy (busy1), .done (done1), .result (res1)
  );

  assign busy_w = sel ? busy1 : busy0;
  assign done_w = sel ? done1 : done0;
  assign res_w  = sel ? res1  : res0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation; T is the negedge-to-posedge cycle in which start is first seen.
  task automatic issue(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat,
                       input logic [31:0] exp_res, input string tag);
    int lat;
    @(negedge clk);
    sel = s; op = o; rs1 = a; rs2 = b;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    #1 chk({tag, ".busyT"}, 64'(busy_w), 64'(exp_lat > 1));
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        rs1 = ~a;
        rs2 = b ^ 32'h0000_5A5A;
      end
      if (done_w) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, 64'(res_w), 64'(exp_res));
    chk({tag, ".busyD"}, 64'(busy_w), 64'd0);
    start0 = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(done_w), 64'd0);
  endtask

  initial begin
    logic seen;

    // reset state, with start asserted to confirm busy is held low
    start0 = 1'b1;
    #2;
    chk("rst.busy0", 64'(busy0), 64'd0);
    chk("rst.done0", 64'(done0), 64'd0);
    chk("rst.res0",  64'(res0),  64'd0);
    chk("rst.busy1", 64'(busy1), 64'd0);
    chk("rst.res1",  64'(res1),  64'd0);
    repeat (3) @(negedge clk);
    start0 = 1'b0;
    rst = 1'b1;

    // products and cache mode rules
    issue(0, 3'b001, 32'hFFFF_FFFF, 32'h2, 10, 32'hFFFF_FFFF, "t1.mulh");
    issue(0, 3'b000, 32'hFFFF_FFFF, 32'h2, 1,  32'hFFFF_FFFE, "t1.mul_hit");
    issue(0, 3'b010, 32'h8000_0000, 32'h3, 10, 32'hFFFF_FFFE, "t1.mulhsu");
    issue(0, 3'b001, 32'h8000_0000, 32'h3, 10, 32'hFFFF_FFFE, "t1.mulh_miss");
    issue(0, 3'b000, 32'h8000_0000, 32'h3, 1,  32'h8000_0000, "t1.mul_lo");

    // signed division, shared quotient/remainder cache entry
    issue(0, 3'b100, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFD, "t2.div");
    issue(0, 3'b110, 32'hFFFF_FFF9, 32'h2, 1,  32'hFFFF_FFFF, "t2.rem_hit");
    issue(0, 3'b111, 32'hFFFF_FFF9, 32'h2, 34, 32'h0000_0001, "t2.remu");

    // fast paths
    issue(0, 3'b101, 32'h0000_1234, 32'h0, 1, 32'hFFFF_FFFF, "t3.divu0");
    issue(0, 3'b111, 32'h0000_1234, 32'h0, 1, 32'h0000_1234, "t3.remu0");
    issue(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "t3.div_ovf");
    issue(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, "t3.rem_ovf");

    // kill at T+5 of a DIV
    @(negedge clk);
    sel = 0; op = 3'b100; rs1 = 32'd100; rs2 = 32'd7; start0 = 1'b1;
    repeat (5) @(posedge clk);
    #1 kill = 1'b1;
    #1 chk("t4.kill_busy", 64'(busy0), 64'd0);
    chk("t4.kill_done", 64'(done0), 64'd0);
    @(posedge clk);
    #1 kill = 1'b0; start0 = 1'b0;
    #1 chk("t4.idle", 64'(busy0), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done0) seen = 1'b1;
    end
    chk("t4.nodone", 64'(seen), 64'd0);
    issue(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFE, "t4.mulhu");

    // kill in the DONE cycle of a cache hit: done suppressed, cache kept
    @(negedge clk);
    op = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start0 = 1'b1;
    #1 chk("kd.busyT", 64'(busy0), 64'd0);
    @(posedge clk);
    #1 kill = 1'b1;
    #1 chk("kd.done", 64'(done0), 64'd0);
    @(negedge clk);
    kill = 1'b0; start0 = 1'b0;
    issue(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, "kd.rehit");

    // asynchronous reset mid-MUL clears outputs and invalidates the cache
    issue(0, 3'b100, 32'd1000, 32'd3, 34, 32'd333, "t5.div");
    @(negedge clk);
    op = 3'b000; rs1 = 32'd5; rs2 = 32'd6; start0 = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("t5.busy", 64'(busy0), 64'd0);
    chk("t5.done", 64'(done0), 64'd0);
    chk("t5.res",  64'(res0),  64'd0);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(0, 3'b100, 32'd1000, 32'd3, 34, 32'd333, "t5.redo");

    // alternative radix instance
    issue(1, 3'b000, 32'd7,   32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, "t6.mul");
    issue(1, 3'b101, 32'd100, 32'd7,         18, 32'd14,        "t6.divu");
    issue(1, 3'b110, 32'hFFFF_FF9C, 32'd7,   18, 32'hFFFF_FFFE, "t6.rem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised, iterative RV32M/RV64M multiply–divide unit for the execute stage. It replaces the separate fixed-width multiplier and divider with one shared datapath. It adds configurable radix, a divide-by-zero/overflow fast path, a last-result operand cache and a kill input for branch/jump flushes. It sits beside the ALU, takes forwarded rs1/rs2, and stalls the pipeline through `busy` until `done`.

## Interface
- `XLEN`, 32: operand/result width; ≥8; multiple of both step parameters.
- `MUL_BITS`, 4: multiplier bits retired per cycle (1, 2, 4 or 8).
- `DIV_BITS`, 1: quotient bits retired per cycle (1 or 2).
- `clk  in  1  clock; all state on rising edge.`
- `rst  in  1  reset; asynchronous, active-low.`
- `start  in  1  request valid; held by EX until done.`
- `op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.`
- `rs1  in  XLEN  forwarded dividend/multiplicand.`
- `rs2  in  XLEN  forwarded divisor/multiplier.`
- `kill  in  1  abort the current operation (flush).`
- `busy  out  1  combinational stall request.`
- `done  out  1  one-cycle result-valid pulse.`
- `result  out  XLEN  registered; held until the next done.`

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1, kill=0:
  - Fast path or cache hit → DONE.
  - Otherwise latch operand magnitudes and sign flags, clear the counter, go to MUL or DIV by op[2].
- MUL: radix-2^MUL_BITS shift-add over a 2·XLEN accumulator, N=XLEN/MUL_BITS steps. MULHSU treats rs1 signed and rs2 unsigned.
- DIV: restoring division, N=XLEN/DIV_BITS steps, via `muldiv_div_step`.
- FIX (1 cycle):
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Select lo/hi or quotient/remainder.
  - Write the cache; go to DONE.
- DONE: done=1 for one cycle. start is ignored (it is the same instruction). Go to IDLE.
- Fast path (signed/unsigned as per op):
  - rs2=0: DIV/DIVU → all-ones; REM/REMU → rs1.
  - Signed rs1=MIN, rs2=−1: DIV → MIN; REM → 0.
- Cache contents: last operands, 2·XLEN product plus its signedness mode, or quotient+remainder plus its signedness.
- Cache hit rules:
  - MUL hits on any cached product with equal rs1/rs2.
  - MULH* hits only with the same mode.
  - DIV/REM hit each other with equal operands and signedness.
- kill:
  - Priority over start.
  - Any state except DONE → IDLE next edge; no done; cache unchanged.
  - kill in the DONE cycle → done output gated low; cache remains valid.
- Reset: state IDLE, cache invalid, busy=0, done=0, result=0.

## Timing
- T = IDLE cycle with start=1.
- Full operation: iterate cycles T+1..T+N, FIX at T+N+1, done at T+N+2.
  - Defaults: MUL done at T+10, DIV done at T+34.
- Fast path or cache hit: done at T+1.
- busy = (state∈{MUL,DIV,FIX}) | (IDLE & start & ~hit & ~fast) | …, forced 0 while kill=1.
  - busy is 0 in the DONE cycle, so EX advances exactly on done.
- Counter width $clog2(N)+1. Terminal step occurs when the counter reaches N−1.
- Operand changes after T are ignored. Only the latched copies are used.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum (the funct3 encodings above).
  - `muldiv_state_t`.
  - Helper constants `MUL_STEPS`/`DIV_STEPS` as functions of the parameters.
- Sub-module `muldiv_div_step`: combinational DIV_BITS-wide restoring step (partial remainder, divisor → new remainder, quotient bits).
- Multiplier step stays inline.

## Test plan
1. MULH rs1=0xFFFFFFFF, rs2=0x2 → result 0xFFFFFFFF, done at T+10. Then MUL with same operands → cache hit, 0xFFFFFFFE at T+1.
2. DIV rs1=0xFFFFFFF9, rs2=0x2 → 0xFFFFFFFD at T+34. Then REM with same operands → 0xFFFFFFFF at T+1. Then REMU with same operands → miss, 0x1 at T+34.
3. DIVU rs1=0x1234, rs2=0 → 0xFFFFFFFF at T+1. REMU → 0x1234 at T+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM → 0.
4. kill at T+5 of a DIV → busy 0 that cycle, no done, IDLE at T+6. Next MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE at +10.
5. rst low asynchronously mid-MUL → busy/done/result 0 immediately. A repeated prior DIV after release misses the cache (full latency).
6. XLEN=32, MUL_BITS=1, DIV_BITS=2 → MUL 7×−3 = 0xFFFFFFEB at T+34. DIVU 100/7 = 14 at T+18.
